nibble_sequencer: RTL

Fetch/decode/execute controller for the 4-bit accumulator datapath (operand bus driver `enB1`, accumulator `en_accu`, ALU select `S`, output buffer `enB2`). It reads 8-bit instruction bytes from program ROM, drives the datapath enables one instruction at a time, keeps a carry/zero flag register, and runs conditional jumps. It sits between the program ROM and the datapath.

---
 rtl/nibble_pkg.sv | 38 +++
 rtl/program_counter.sv | 28 ++
 rtl/nibble_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared opcodes, ALU selects and state encoding for the nibble sequencer
package nibble_pkg;

    localparam int PC_W_DEFAULT = 8;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LIT   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_SUBI  = 4'h3;
    localparam logic [3:0] OP_NANDI = 4'h4;
    localparam logic [3:0] OP_CMPI  = 4'h5;
    localparam logic [3:0] OP_OUT   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JC    = 4'h8;
    localparam logic [3:0] OP_JNC   = 4'h9;
    localparam logic [3:0] OP_JZ    = 4'hA;
    localparam logic [3:0] OP_JNZ   = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hC;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_PASSB = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b011;
    localparam logic [2:0] ALU_NAND  = 3'b100;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_JLOAD = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Arithmetic/logic immediates and compare are the only opcodes that capture ALU flags
    function automatic logic updates_flags(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_NANDI) || (op == OP_CMPI);
    endfunction

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC register with increment and absolute load
module program_counter
    import nibble_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // Load wins over increment; increment wraps naturally at the top of the address space
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_ONE;
        end
    end

endmodule

// File: rtl/nibble_sequencer.sv
// rtl/nibble_sequencer.sv - fetch/decode/execute controller for the 4-bit accumulator datapath
module nibble_sequencer
    import nibble_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [7:0]      program_byte,
    input  logic            carry_in,
    input  logic            zero_in,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      oprnd,
    output logic            enB1,
    output logic            en_accu,
    output logic [2:0]      S,
    output logic            enB2,
    output logic            flag_c,
    output logic            flag_z,
    output logic            halted
);

    state_t     state;
    logic [7:0] ir;
    logic [3:0] op;
    logic       jump_taken;
    logic       is_jump;
    logic       pc_inc;
    logic       pc_load;

    assign op     = ir[7:4];
    assign oprnd  = ir[3:0];
    assign halted = (state == ST_HALT);

    // Moore decode: enables depend only on registered state and IR, so reset clears them at once
    always_comb begin
        enB1       = 1'b0;
        en_accu    = 1'b0;
        enB2       = 1'b0;
        S          = ALU_PASSA;
        is_jump    = 1'b0;
        jump_taken = 1'b0;
        if (state == ST_EXEC) begin
            case (op)
                OP_LIT:   begin enB1 = 1'b1; S = ALU_PASSB; en_accu = 1'b1; end
                OP_ADDI:  begin enB1 = 1'b1; S = ALU_ADD;   en_accu = 1'b1; end
                OP_SUBI:  begin enB1 = 1'b1; S = ALU_SUB;   en_accu = 1'b1; end
                OP_NANDI: begin enB1 = 1'b1; S = ALU_NAND;  en_accu = 1'b1; end
                OP_CMPI:  begin enB1 = 1'b1; S = ALU_SUB; end
                OP_OUT:   begin enB2 = 1'b1; S = ALU_PASSA; end
                OP_JMP:   begin is_jump = 1'b1; jump_taken = 1'b1; end
                OP_JC:    begin is_jump = 1'b1; jump_taken = flag_c; end
                OP_JNC:   begin is_jump = 1'b1; jump_taken = !flag_c; end
                OP_JZ:    begin is_jump = 1'b1; jump_taken = flag_z; end
                OP_JNZ:   begin is_jump = 1'b1; jump_taken = !flag_z; end
                default:  ;
            endcase
        end
    end

    // Advance past the opcode byte on fetch, or past an unused jump target byte
    assign pc_inc  = ((state == ST_FETCH) && run) || (is_jump && !jump_taken);
    assign pc_load = (state == ST_JLOAD);

    program_counter #(
        .PC_W (PC_W)
    ) u_pc (
        .clk      (clk),
        .rst_n    (reset),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (PC_W'(program_byte)),
        .pc       (pc)
    );

    // Instruction sequencing, IR capture and flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_FETCH;
            ir     <= 8'h00;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (run) begin
                        ir    <= program_byte;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (updates_flags(op)) begin
                        flag_c <= carry_in;
                        flag_z <= zero_in;
                    end
                    if (op == OP_HALT) begin
                        state <= ST_HALT;
                    end else if (jump_taken) begin
                        state <= ST_JLOAD;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_JLOAD: state <= ST_FETCH;
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_FETCH;
            endcase
        end
    end

endmodule
